// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// State encoding, statistics width and index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or above ptr,
// wrapping modulo N back to index 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    logic [IW-1:0] j;
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Optional per-requester counters: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int Width     = 16,
  parameter  int BURST_MAX = 4,
  localparam int IW        = idx_w(N_REQ),
  localparam int BW        = $clog2(BURST_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*Width-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_write_en,
  output logic [Width-1:0]       fifo_d_in,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0] stat_count,
`endif
  output logic [IW-1:0]          grant_id,
  output logic                   busy
);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [BW-1:0]   burst_cnt;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [N_REQ-1:0] xfer;
  logic [IW-1:0]   next_ptr;
  logic [Width-1:0] data_arr [N_REQ];

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*Width +: Width];
  end

  // Owner is ready only while granted, not stalled, not in reset.
  always_comb begin
    req_ready = '0;
    if (state == GRANT && !fifo_full && !rst)
      req_ready[grant_id] = 1'b1;
  end

  assign xfer          = req_valid & req_ready;
  assign fifo_write_en = |xfer;
  assign fifo_d_in     = data_arr[grant_id];
  assign busy          = (state == GRANT) && !rst;
  assign next_ptr      = (grant_id == IW'(N_REQ - 1)) ?
                         '0 : grant_id + 1'b1;

  // Arbitration FSM: one idle cycle to pick, bounded burst in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      grant_id  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_idx;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req_valid[grant_id]) begin
            rr_ptr    <= next_ptr;
            burst_cnt <= '0;
            state     <= IDLE;
          end else if (fifo_write_en &&
                       burst_cnt == BW'(BURST_MAX - 1)) begin
            rr_ptr    <= next_ptr;
            burst_cnt <= '0;
            state     <= IDLE;
          end else if (fifo_write_en) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // Saturating per-requester transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_count <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (xfer[i] && stat_count[i*STAT_W +: STAT_W] != '1)
          stat_count[i*STAT_W +: STAT_W] <=
            stat_count[i*STAT_W +: STAT_W] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, Width=16, BURST_MAX=4).
// Requesters are modelled as word sources; expectations are hand-derived.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BM = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_write_en;
  logic [W-1:0]   fifo_d_in;
  logic [1:0]     grant_id;
  logic           busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*STAT_W-1:0] stat_count;
`endif

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .Width     (W),
    .BURST_MAX (BM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_d_in     (fifo_d_in),
`ifdef FIFO_WR_ARB_STATS_EN
    .stat_count    (stat_count),
`endif
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int rem  [N];
  int sent [N];
  logic rst_v  = 1'b1;
  logic full_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic apply();
    rst       = rst_v;
    fifo_full = full_v;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rem[i] > 0;
      req_data[i*W +: W] = 16'((i << 12) | (sent[i] & 12'hFFF));
    end
    #1;
  endtask

  task automatic tick();
    logic [N-1:0] x;
    x = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (x[i]) begin
        sent[i]++;
        rem[i]--;
      end
    apply();
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_v  = 1'b1;
    full_v = 1'b0;
    clear_src();
    apply();
    tick();
    rst_v = 1'b0;
  endtask

  int we1 [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int bz1 [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  int we3 [10] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 0};
  int bz3 [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int fl3 [10] = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 0};

  initial begin
    int k;
    int g;
    int ph;
    int word;
    int bound;

    // Reset gating with every requester valid.
    rst_v = 1'b1;
    clear_src();
    for (int i = 0; i < N; i++) rem[i] = 1;
    apply();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_we", 32'(fifo_write_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single requester, 6 words: 4-beat burst, bubble, 2 more.
    do_reset();
    rem[1] = 6;
    apply();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      chk($sformatf("t1_we%0d", c), 32'(fifo_write_en), 32'(we1[c]));
      chk($sformatf("t1_bz%0d", c), 32'(busy), 32'(bz1[c]));
      if (we1[c] == 1) begin
        chk($sformatf("t1_gid%0d", c), 32'(grant_id), 32'd1);
        chk($sformatf("t1_d%0d", c), 32'(fifo_d_in), 32'(16'h1000 + k));
        k++;
      end
    end

    // All requesters with 16 words: 0,1,2,3 rotation, 4 beats each.
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 16;
    apply();
    for (int c = 0; c < 81; c++) begin
      if (c > 0) tick();
      g  = (c / 5) % 4;
      ph = c % 5;
      word = (c / 20) * 4 + ph - 1;
      if (c == 80 || ph == 0) begin
        chk($sformatf("t2_we%0d", c), 32'(fifo_write_en), 32'd0);
        chk($sformatf("t2_bz%0d", c), 32'(busy), 32'd0);
      end else begin
        chk($sformatf("t2_we%0d", c), 32'(fifo_write_en), 32'd1);
        chk($sformatf("t2_gid%0d", c), 32'(grant_id), 32'(g));
        chk($sformatf("t2_d%0d", c), 32'(fifo_d_in),
            32'(16'((g << 12) | word)));
      end
    end

    // FIFO full mid-burst of requester 2, and on its final beat.
    do_reset();
    rem[2] = 8;
    apply();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        full_v = fl3[c] != 0;
        tick();
      end
      chk($sformatf("t3_we%0d", c), 32'(fifo_write_en), 32'(we3[c]));
      chk($sformatf("t3_bz%0d", c), 32'(busy), 32'(bz3[c]));
      if (bz3[c] == 1)
        chk($sformatf("t3_gid%0d", c), 32'(grant_id), 32'd2);
      if (fl3[c] == 1)
        chk($sformatf("t3_rdy%0d", c), 32'(req_ready), 32'd0);
      if (we3[c] == 1) begin
        chk($sformatf("t3_d%0d", c), 32'(fifo_d_in), 32'(16'h2000 + k));
        k++;
      end
    end
    full_v = 1'b0;

    // Requester 3 drops valid after 2 words; pointer wraps to 0.
    do_reset();
    rem[3] = 2;
    apply();
    chk("t4_idle", 32'(busy), 32'd0);
    rem[0] = 4;
    rem[1] = 4;
    tick();
    chk("t4_gid1", 32'(grant_id), 32'd3);
    chk("t4_we1", 32'(fifo_write_en), 32'd1);
    tick();
    chk("t4_d2", 32'(fifo_d_in), 32'h3001);
    tick();
    chk("t4_drop_we", 32'(fifo_write_en), 32'd0);
    chk("t4_drop_bz", 32'(busy), 32'd1);
    tick();
    chk("t4_bubble", 32'(busy), 32'd0);
    tick();
    chk("t4_next_gid", 32'(grant_id), 32'd0);
    chk("t4_next_we", 32'(fifo_write_en), 32'd1);
    chk("t4_next_d", 32'(fifo_d_in), 32'h0000);

    // Reset during requester 1's burst restarts from requester 0.
    do_reset();
    rem[1] = 8;
    apply();
    tick();
    chk("t5_gid1", 32'(grant_id), 32'd1);
    rem[0] = 4;
    rem[2] = 4;
    tick();
    chk("t5_we2", 32'(fifo_write_en), 32'd1);
    rst_v = 1'b1;
    tick();
    chk("t5_rst_we", 32'(fifo_write_en), 32'd0);
    chk("t5_rst_bz", 32'(busy), 32'd0);
    rst_v = 1'b0;
    tick();
    chk("t5_idle", 32'(busy), 32'd0);
    tick();
    chk("t5_gid0", 32'(grant_id), 32'd0);
    chk("t5_d0", 32'(fifo_d_in), 32'h0000);

`ifdef FIFO_WR_ARB_STATS_EN
    // Saturation of requester 0's counter.
    do_reset();
    rem[0] = 65540;
    apply();
    bound = 0;
    while (rem[0] > 0 && bound < 90000) begin
      tick();
      bound++;
    end
    chk("t6_done", 32'(rem[0]), 32'd0);
    chk("t6_sat0", 32'(stat_count[15:0]), 32'h0000FFFF);
    chk("t6_cnt1", 32'(stat_count[31:16]), 32'd0);
    chk("t6_cnt2", 32'(stat_count[47:32]), 32'd0);
    chk("t6_cnt3", 32'(stat_count[63:48]), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
